alu4_issue: RTL

ALU4_ISSUE -- requirements
Module: alu4_issue

---
 rtl/alu4_issue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu4_issue.sv
// Issue stage for a 4-bit ALU: a 4-entry request FIFO feeds one operation at a time.
// The ALU result and flags are held in a register until the consumer accepts them.
module alu4_issue (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_n1,
  input  logic [3:0] in_n2,
  input  logic [1:0] in_op,
  output logic [3:0] alu_n1,
  output logic [3:0] alu_n2,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_neg,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_out,
  output logic       res_carry,
  output logic       res_zero,
  output logic       res_neg,
  output logic [2:0] occupancy
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t     state;
  state_t     state_next;
  logic [9:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [9:0] head;
  logic       push;
  logic       pop;
  logic       capture;
  logic       release_res;

  // in_ready looks only at the registered count, so a same-edge pop never frees a slot early
  assign in_ready = !rst && (occupancy < 3'd4);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (occupancy != 3'd0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          release_res = 1'b1;
          if (occupancy != 3'd0) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Storage needs no reset: push is blocked while rst is high and the count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_n1, in_n2, in_op};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      occupancy <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      occupancy <= occupancy + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_n1 <= 4'd0;
      alu_n2 <= 4'd0;
      alu_op <= 2'd0;
    end else if (pop) begin
      alu_n1 <= head[9:6];
      alu_n2 <= head[5:2];
      alu_op <= head[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_out   <= 4'd0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_out   <= alu_out;
      res_carry <= alu_carry;
      res_zero  <= alu_zero;
      res_neg   <= alu_neg;
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

endmodule
